// File: rtl/regfile_mp_pkg.sv
// Shared Y86-64 register-file definitions: specifier encodings, default sizes
// and a specifier range check used by fetch, decode and writeback.
package regfile_mp_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 4;
  localparam int NUM_REGS_DEF = 15;
  localparam int NUM_RD_DEF   = 2;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RAX   = 4'h0;
  localparam logic [3:0] RCX   = 4'h1;
  localparam logic [3:0] RDX   = 4'h2;
  localparam logic [3:0] RBX   = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RBP   = 4'h5;
  localparam logic [3:0] RSI   = 4'h6;
  localparam logic [3:0] RDI   = 4'h7;
  localparam logic [3:0] R8    = 4'h8;
  localparam logic [3:0] R9    = 4'h9;
  localparam logic [3:0] R10   = 4'hA;
  localparam logic [3:0] R11   = 4'hB;
  localparam logic [3:0] R12   = 4'hC;
  localparam logic [3:0] R13   = 4'hD;
  localparam logic [3:0] R14   = 4'hE;

  // A specifier names a real register only when it is below the register count;
  // RNONE always falls outside because the count never exceeds 15.
  function automatic logic spec_valid(input int spec, input int num_regs);
    return (spec < num_regs);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of read, write and scoreboard signals between decode/writeback and
// the register file. The register file is the slave side.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_busy_o;
  logic                     wrE_en_i;
  logic [ADDR_W-1:0]        dstE_i;
  logic [DATA_W-1:0]        valE_i;
  logic                     wrM_en_i;
  logic [ADDR_W-1:0]        dstM_i;
  logic [DATA_W-1:0]        valM_i;
  logic                     alloc_en_i;
  logic [ADDR_W-1:0]        alloc_dst_i;
  logic [NUM_REGS-1:0]      busy_o;

  modport master (
    output rd_addr_i, wrE_en_i, dstE_i, valE_i, wrM_en_i, dstM_i, valM_i,
           alloc_en_i, alloc_dst_i,
    input  rd_data_o, rd_busy_o, busy_o
  );

  modport slave (
    input  rd_addr_i, wrE_en_i, dstE_i, valE_i, wrM_en_i, dstM_i, valM_i,
           alloc_en_i, alloc_dst_i,
    output rd_data_o, rd_busy_o, busy_o
  );

endinterface

// File: rtl/regfile_mp_rd_port.sv
// One combinational read port: specifier check, optional same-cycle write
// bypass (M ahead of E) and busy masking for a write landing this cycle.
module regfile_mp_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic                wrE_ok,
  input  logic [ADDR_W-1:0]   dstE,
  input  logic [DATA_W-1:0]   valE,
  input  logic                wrM_ok,
  input  logic [ADDR_W-1:0]   dstM,
  input  logic [DATA_W-1:0]   valM,
  output logic [DATA_W-1:0]   data,
  output logic                rd_busy
);

  logic addr_ok;
  logic hitE;
  logic hitM;

  // Select stored or in-flight data; RNONE reads as zero and never busy
  always_comb begin
    addr_ok = spec_valid(int'(addr), NUM_REGS);
    hitE    = wrE_ok && (dstE == addr);
    hitM    = wrM_ok && (dstM == addr);
    data    = '0;
    rd_busy = 1'b0;
    if (addr_ok) begin
      data    = regs[addr];
      rd_busy = busy[addr];
      if (BYPASS != 0) begin
        if (hitM) begin
          data = valM;
        end else if (hitE) begin
          data = valE;
        end
        if (hitE || hitM) begin
          rd_busy = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Pipelined Y86-64 register file: NUM_RD read ports, E and M write ports with
// M winning collisions, and a busy-bit scoreboard of in-flight destinations.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int BYPASS   = 1
) (
  input logic         clk_i,
  input logic         rst_i,
  regfile_mp_if.slave bus
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                wrE_ok;
  logic                wrM_ok;
  logic                alloc_ok;

  assign wrE_ok   = bus.wrE_en_i   && spec_valid(int'(bus.dstE_i), NUM_REGS);
  assign wrM_ok   = bus.wrM_en_i   && spec_valid(int'(bus.dstM_i), NUM_REGS);
  assign alloc_ok = bus.alloc_en_i && spec_valid(int'(bus.alloc_dst_i), NUM_REGS);
  assign bus.busy_o = busy;

  // Storage update: E is applied first so an M write to the same register wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wrE_ok) begin
        regs[bus.dstE_i] <= bus.valE_i;
      end
      if (wrM_ok) begin
        regs[bus.dstM_i] <= bus.valM_i;
      end
    end
  end

  // Scoreboard next state: commits clear, then a new allocation sets (younger producer wins)
  always_comb begin
    busy_next = busy;
    if (wrE_ok) begin
      busy_next[bus.dstE_i] = 1'b0;
    end
    if (wrM_ok) begin
      busy_next[bus.dstM_i] = 1'b0;
    end
    if (alloc_ok) begin
      busy_next[bus.alloc_dst_i] = 1'b1;
    end
  end

  // Scoreboard register, cleared on reset regardless of same-cycle traffic
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .BYPASS   (BYPASS)
    ) u_rd (
      .addr    (bus.rd_addr_i[k*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .busy    (busy),
      .wrE_ok  (wrE_ok),
      .dstE    (bus.dstE_i),
      .valE    (bus.valE_i),
      .wrM_ok  (wrM_ok),
      .dstM    (bus.dstM_i),
      .valM    (bus.valM_i),
      .data    (bus.rd_data_o[k*DATA_W +: DATA_W]),
      .rd_busy (bus.rd_busy_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by a
// randomized run, with expectations queued when stimulus is applied.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int DW  = 64;
  localparam int AW  = 4;
  localparam int NR  = 15;
  localparam int NRD = 2;
  localparam int BYP = 1;

  logic clk_i = 1'b0;
  logic rst_i;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] exp_q [$];
  logic [63:0] m_regs [NR];
  logic [NR-1:0] m_busy;

  always #5 clk_i = ~clk_i;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(BYP)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic logic [63:0] rd_data(input int k);
    return bus.rd_data_o[k*DW +: DW];
  endfunction

  task automatic set_rd(input int k, input logic [3:0] a);
    bus.rd_addr_i[k*AW +: AW] = a;
  endtask

  task automatic idle();
    rst_i           = 1'b0;
    bus.wrE_en_i    = 1'b0;
    bus.dstE_i      = '0;
    bus.valE_i      = '0;
    bus.wrM_en_i    = 1'b0;
    bus.dstM_i      = '0;
    bus.valM_i      = '0;
    bus.alloc_en_i  = 1'b0;
    bus.alloc_dst_i = '0;
    bus.rd_addr_i   = '0;
  endtask

  // Reference model of the expected combinational read data
  function automatic logic [63:0] m_rd_data(input logic [3:0] a);
    logic [63:0] r;
    if (int'(a) >= NR) return 64'h0;
    r = m_regs[a];
    if (BYP != 0) begin
      if (bus.wrE_en_i && bus.dstE_i == a) r = bus.valE_i;
      if (bus.wrM_en_i && bus.dstM_i == a) r = bus.valM_i;
    end
    return r;
  endfunction

  // Reference model of the expected per-port busy flag
  function automatic logic m_rd_busy(input logic [3:0] a);
    logic b;
    if (int'(a) >= NR) return 1'b0;
    b = m_busy[a];
    if (BYP != 0) begin
      if ((bus.wrE_en_i && bus.dstE_i == a) || (bus.wrM_en_i && bus.dstM_i == a)) b = 1'b0;
    end
    return b;
  endfunction

  // Reference model state update at the clock edge
  task automatic m_commit();
    logic [NR-1:0] nb;
    if (rst_i) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      nb = m_busy;
      if (bus.wrE_en_i && int'(bus.dstE_i) < NR) begin
        m_regs[bus.dstE_i] = bus.valE_i;
        nb[bus.dstE_i] = 1'b0;
      end
      if (bus.wrM_en_i && int'(bus.dstM_i) < NR) begin
        m_regs[bus.dstM_i] = bus.valM_i;
        nb[bus.dstM_i] = 1'b0;
      end
      if (bus.alloc_en_i && int'(bus.alloc_dst_i) < NR) nb[bus.alloc_dst_i] = 1'b1;
      m_busy = nb;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    m_commit();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    logic [63:0] got, exp;
    idle();
    rst_i = 1'b1;
    step();
    idle();
    set_rd(0, 4'd0);
    set_rd(1, 4'd14);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    #1;
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL reset_rd0 got=%h exp=%h", got, exp); end
    got = rd_data(1); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL reset_rd14 got=%h exp=%h", got, exp); end
    got = 64'(bus.busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL reset_busy got=%h exp=%h", got, exp); end
    got = 64'(bus.rd_busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL reset_rd_busy got=%h exp=%h", got, exp); end
    set_rd(0, RNONE);
    exp_q.push_back(64'h0);
    #1;
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL reset_rnone got=%h exp=%h", got, exp); end
    step();
  endtask

  task automatic test_basic_write();
    logic [63:0] got, exp;
    idle();
    set_rd(0, 4'd3);
    bus.wrE_en_i = 1'b1; bus.dstE_i = 4'd3; bus.valE_i = 64'h1234;
    exp_q.push_back((BYP != 0) ? 64'h1234 : 64'h0);
    #1;
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL basic_same_cycle got=%h exp=%h", got, exp); end
    step();
    idle();
    set_rd(0, 4'd3);
    set_rd(1, 4'd2);
    exp_q.push_back(64'h1234);
    exp_q.push_back(64'h0);
    #1;
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL basic_next_cycle got=%h exp=%h", got, exp); end
    got = rd_data(1); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL basic_other_reg got=%h exp=%h", got, exp); end
    step();
  endtask

  task automatic test_collision();
    logic [63:0] got, exp;
    idle();
    set_rd(0, RSP);
    set_rd(1, RSP);
    bus.wrE_en_i = 1'b1; bus.dstE_i = RSP; bus.valE_i = 64'hAA;
    bus.wrM_en_i = 1'b1; bus.dstM_i = RSP; bus.valM_i = 64'hBB;
    exp_q.push_back((BYP != 0) ? 64'hBB : 64'h0);
    #1;
    got = rd_data(1); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL collide_bypass got=%h exp=%h", got, exp); end
    step();
    idle();
    set_rd(0, RSP);
    exp_q.push_back(64'hBB);
    #1;
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL collide_stored got=%h exp=%h", got, exp); end
    step();
  endtask

  task automatic test_scoreboard();
    logic [63:0] got, exp;
    idle();
    bus.alloc_en_i = 1'b1; bus.alloc_dst_i = 4'd2;
    step();
    idle();
    set_rd(0, 4'd2);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h1);
    #1;
    got = 64'(bus.busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL sb_alloc_busy got=%h exp=%h", got, exp); end
    got = 64'(bus.rd_busy_o[0]); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL sb_alloc_rd_busy got=%h exp=%h", got, exp); end
    bus.wrM_en_i = 1'b1; bus.dstM_i = 4'd2; bus.valM_i = 64'h77;
    exp_q.push_back((BYP != 0) ? 64'h0 : 64'h1);
    exp_q.push_back((BYP != 0) ? 64'h77 : 64'h0);
    exp_q.push_back(64'h4);
    #1;
    got = 64'(bus.rd_busy_o[0]); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL sb_write_rd_busy got=%h exp=%h", got, exp); end
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL sb_write_data got=%h exp=%h", got, exp); end
    got = 64'(bus.busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL sb_busy_no_bypass got=%h exp=%h", got, exp); end
    step();
    idle();
    set_rd(0, 4'd2);
    exp_q.push_back(64'h0);
    #1;
    got = 64'(bus.busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL sb_cleared got=%h exp=%h", got, exp); end
    bus.alloc_en_i = 1'b1; bus.alloc_dst_i = 4'd2;
    bus.wrE_en_i = 1'b1; bus.dstE_i = 4'd2; bus.valE_i = 64'h5;
    step();
    idle();
    set_rd(0, 4'd2);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h1);
    exp_q.push_back(64'h5);
    #1;
    got = 64'(bus.busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL sb_set_wins got=%h exp=%h", got, exp); end
    got = 64'(bus.rd_busy_o[0]); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL sb_set_wins_rd got=%h exp=%h", got, exp); end
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL sb_set_wins_data got=%h exp=%h", got, exp); end
    step();
  endtask

  task automatic test_rnone();
    logic [63:0] got, exp;
    idle();
    set_rd(0, RNONE);
    set_rd(1, RNONE);
    bus.wrE_en_i = 1'b1; bus.dstE_i = RNONE; bus.valE_i = 64'hFF;
    bus.alloc_en_i = 1'b1; bus.alloc_dst_i = RNONE;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    #1;
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL rnone_data got=%h exp=%h", got, exp); end
    got = 64'(bus.rd_busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL rnone_rd_busy got=%h exp=%h", got, exp); end
    step();
    idle();
    exp_q.push_back(64'h4);
    #1;
    got = 64'(bus.busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL rnone_busy_kept got=%h exp=%h", got, exp); end
    for (int i = 0; i < NR; i++) begin
      set_rd(1, 4'(i));
      exp_q.push_back(m_regs[i]);
      #1;
      got = rd_data(1); exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("[TB] FAIL rnone_reg%0d got=%h exp=%h", i, got, exp); end
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [63:0] got, exp;
    idle();
    bus.wrE_en_i = 1'b1; bus.dstE_i = 4'd5; bus.valE_i = 64'h55;
    bus.alloc_en_i = 1'b1; bus.alloc_dst_i = 4'd6;
    step();
    idle();
    set_rd(0, 4'd5);
    exp_q.push_back(64'h55);
    exp_q.push_back(64'h44);
    #1;
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL mid_pre_reg5 got=%h exp=%h", got, exp); end
    got = 64'(bus.busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL mid_pre_busy got=%h exp=%h", got, exp); end
    rst_i = 1'b1;
    bus.wrE_en_i = 1'b1; bus.dstE_i = 4'd5; bus.valE_i = 64'h99;
    bus.alloc_en_i = 1'b1; bus.alloc_dst_i = 4'd7;
    step();
    idle();
    set_rd(0, 4'd5);
    set_rd(1, RSP);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    #1;
    got = rd_data(0); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL mid_reg5 got=%h exp=%h", got, exp); end
    got = rd_data(1); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL mid_reg4 got=%h exp=%h", got, exp); end
    got = 64'(bus.busy_o); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("[TB] FAIL mid_busy got=%h exp=%h", got, exp); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [63:0] got, exp;
    logic [3:0]  a;
    for (int n = 0; n < 300; n++) begin
      idle();
      rst_i           = ($urandom_range(0, 39) == 0);
      bus.wrE_en_i    = 1'($urandom_range(0, 1));
      bus.dstE_i      = 4'($urandom_range(0, 15));
      bus.valE_i      = {$urandom, $urandom};
      bus.wrM_en_i    = 1'($urandom_range(0, 1));
      bus.dstM_i      = ($urandom_range(0, 3) == 0) ? bus.dstE_i : 4'($urandom_range(0, 15));
      bus.valM_i      = {$urandom, $urandom};
      bus.alloc_en_i  = 1'($urandom_range(0, 1));
      bus.alloc_dst_i = ($urandom_range(0, 3) == 0) ? bus.dstM_i : 4'($urandom_range(0, 15));
      for (int k = 0; k < NRD; k++) begin
        a = ($urandom_range(0, 2) == 0) ? bus.dstE_i : 4'($urandom_range(0, 15));
        set_rd(k, a);
        exp_q.push_back(m_rd_data(a));
        exp_q.push_back(64'(m_rd_busy(a)));
      end
      exp_q.push_back(64'(m_busy));
      #1;
      for (int k = 0; k < NRD; k++) begin
        got = rd_data(k); exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL rand_data cyc=%0d port=%0d got=%h exp=%h", n, k, got, exp); end
        got = 64'(bus.rd_busy_o[k]); exp = exp_q.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL rand_rd_busy cyc=%0d port=%0d got=%h exp=%h", n, k, got, exp); end
      end
      got = 64'(bus.busy_o); exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("[TB] FAIL rand_busy cyc=%0d got=%h exp=%h", n, got, exp); end
      step();
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    idle();
    test_reset();
    test_basic_write();
    test_collision();
    test_scoreboard();
    test_rnone();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the decode-stage register file, sized for the pipelined Y86-64 core.
- Configurable number of combinational read ports and two write ports (E and M) with Y86 priority rules.
- Optional same-cycle write-to-read bypass.
- Busy-bit scoreboard tracking in-flight destinations, so decode can detect load/use and data hazards.

Parameters:
DATA_W, 64, register data width
ADDR_W, 4, register specifier width
NUM_REGS, 15, architectural registers, addresses 0..NUM_REGS-1; address 4'hF (RNONE) is never a register
NUM_RD, 2, number of read ports
BYPASS, 1, 1 = a read returns the data being written in the same cycle; 0 = a read returns the old value

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
rd_addr_i  in  NUM_RD*ADDR_W  read specifiers; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  read data per port
rd_busy_o  out  NUM_RD  per-port flag: the addressed register has a pending write
wrE_en_i  in  1  write enable, E port
dstE_i  in  ADDR_W  E destination
valE_i  in  DATA_W  E data
wrM_en_i  in  1  write enable, M port
dstM_i  in  ADDR_W  M destination
valM_i  in  DATA_W  M data
alloc_en_i  in  1  mark a destination in flight (issued at execute)
alloc_dst_i  in  ADDR_W  register to mark busy
busy_o  out  NUM_REGS  raw scoreboard vector (debug/hazard unit)

Behaviour:
- Reset (rst_i=1 at posedge): all registers cleared to 0 and all busy bits cleared. Reset takes priority over writes and alloc in the same cycle. A reset asserted mid-stream discards pending writes; the next cycle sees a clean file.
- Writes: a port commits at posedge when its enable is 1 and its destination is < NUM_REGS. RNONE and out-of-range destinations are silently ignored.
- Write collision: if both ports target the same register, M wins (popq %rsp semantics).
- Reads are combinational, zero latency.
  - An RNONE or out-of-range address returns 0 and rd_busy_o=0.
  - BYPASS=1: if an enabled, valid write targets the read address this cycle, return the write data, with valM_i ahead of valE_i. Otherwise return stored data.
  - BYPASS=0: always return stored data; a new value is visible the cycle after the write.
- Scoreboard:
  - busy[r] is set at posedge on alloc_en_i with alloc_dst_i=r.
  - busy[r] is cleared at posedge when either write port commits to r.
  - Simultaneous set and clear of the same r: set wins, because the new producer is younger.
  - alloc to RNONE is ignored.
- rd_busy_o[k]:
  - BYPASS=1: busy[addr_k] AND NOT (a valid write to addr_k this cycle).
  - BYPASS=0: busy[addr_k] alone.
- busy_o is registered state only and has no bypass.
- Reset values: rd_data_o=0 (all registers 0), rd_busy_o=0, busy_o=0.
- Widths: no arithmetic is performed. Data are stored unmodified, full DATA_W.

Decomposition:
- Shared package/define file: RNONE (4'hF), register indices (RSP=4, etc.), DATA_W and ADDR_W defaults, shared with fetch/decode/writeback.
- One natural sub-module, regfile_rd_port, instantiated NUM_RD times. It holds the address check, bypass mux and busy mask for one port.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset then read: rst_i=1 for one cycle, then read addresses 0 and 14 -> rd_data_o=0, busy_o=0; read addr 4'hF -> 0.
- Basic write/read: wrE dstE=3 valE=64'h1234 -> next cycle port0 addr3 = 64'h1234. With BYPASS=1, same-cycle read also = 64'h1234; with BYPASS=0 it = old value 0.
- Collision: wrE dstE=4 valE=64'hAA and wrM dstM=4 valM=64'hBB in the same cycle -> reg4 = 64'hBB afterwards; same-cycle bypass read of 4 = 64'hBB.
- Scoreboard: alloc dst=2 -> busy_o[2]=1 and rd_busy_o=1 for addr2. A later wrM dst=2 -> busy clears next cycle; with BYPASS=1, rd_busy_o=0 already in the write cycle. Simultaneous alloc 2 + write 2 -> busy_o[2] stays 1.
- RNONE handling: wrE dstE=4'hF valE=64'hFF, alloc 4'hF -> no register changes, busy_o unchanged, rd_busy_o for 4'hF = 0.
- Reset mid-operation: reg5=64'h55 written, busy[6]=1, then rst_i=1 together with wrE dst=5 valE=64'h99 -> reg5=0, busy_o=0.
